branch_pc_unit: RTL and testbench
=================================

# branch_pc_unit

Program-counter and branch-resolution unit for the 8-bit core. It consumes the `equal` / `lessThan` flags produced by the ALU on compare instructions and holds them in a flag register. It resolves conditional branches against those registered flags through a small target lookup table, and sequences the PC through idle, run and halt.

## Interface
Parameters:
- PC_W, 10, program counter width in bits
- LUT_AW, 4, branch-target LUT index width (2^LUT_AW entries, each PC_W bits)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin execution from PC 0 (accepted in IDLE or HALT)
- stall  input  1  freeze all state (PC, flags, FSM) this cycle
- halt_req  input  1  current instruction is HALT
- flag_we  input  1  current instruction is a compare; capture flags
- equal_in  input  1  ALU equal flag
- lessThan_in  input  1  ALU lessThan flag
- branch_en  input  1  current instruction is a branch
- branch_cond  input  2  00 always, 01 if equal, 10 if lessThan, 11 if not equal
- lut_idx  input  LUT_AW  branch-target LUT entry selected by the branch
- lut_we  input  1  write LUT entry lut_waddr
- lut_waddr  input  LUT_AW  LUT write address
- lut_wdata  input  PC_W  LUT write data
- pc  output  PC_W  current program counter
- taken  output  1  one-cycle pulse: pc now holds a branch target
- running  output  1  FSM in RUN
- done  output  1  FSM in HALT

## Operation
- FSM states: IDLE, RUN, HALT.
  - IDLE -start-> RUN.
  - RUN -halt_req (not stalled)-> HALT.
  - HALT -start-> RUN.
  - No other transitions.
- Entering RUN from IDLE or HALT:
  - pc←0, flag register cleared (eq=0, lt=0), taken=0.
- RUN, stall=0, evaluated in this priority:
  - halt_req=1: go to HALT and hold pc. Branch and flag inputs are ignored.
  - Otherwise, branch_en=1 and the condition is true on the **registered** flags: pc←LUT[lut_idx], taken←1.
  - Otherwise: pc←pc+1, modulo 2^PC_W (all-ones wraps to 0). taken←0.
  - flag_we=1 (and not halting): eq←equal_in, lt←lessThan_in. A branch in the same cycle uses the old flags.
- Condition for branch_cond=11 is !eq.
- RUN, stall=1:
  - pc, flags and state hold. taken←0. halt_req, branch_en and flag_we are ignored.
- IDLE/HALT:
  - pc and flags hold. taken=0. Branch, flag and stall inputs are ignored.
- LUT:
  - Writable in any state, including during stall.
  - Read is combinational on lut_idx.
  - A write and a branch read to the same entry in one cycle return the old entry.
  - All entries reset to 0.
- running = (state==RUN); done = (state==HALT). Both are decoded from registered state.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, pc=0, eq=lt=0, taken=0, running=0, done=0, all LUT entries 0. Deassertion takes effect at the next clock edge.
- start sampled at edge N: running=1 and pc=0 after edge N.
- Branch decided at edge N: pc=target and taken=1 after edge N. taken drops after edge N+1 unless another taken branch occurs. No bubble cycles.
- Flag captured at edge N: visible to a branch evaluated at edge N+1 or later.
- halt_req at edge N: done=1 and running=0 after edge N. pc keeps its pre-halt value.
- rst_n asserted mid-RUN: immediate return to the reset values above. The LUT is cleared.
- start while in RUN: ignored.

## Test plan
- Reset then start, no branches, 5 cycles -> pc 0,1,2,3,4; running=1; taken=0 throughout.
- LUT[3]=0x120; flag_we with equal_in=1; next cycle branch_en, cond=01, idx=3 -> pc=0x120 next cycle, taken pulses exactly one cycle.
- flag_we (equal_in=1) and branch cond=01 in the same cycle, flags previously 0 -> not taken, pc+1. Same branch one cycle later -> taken.
- PC_W=10, pc at 0x3FF with no branch -> pc=0x000. stall=1 for 3 cycles at pc=0x005 -> pc stays 0x005, flag_we and halt_req ignored.
- halt_req at pc=0x010 -> done=1, running=0, pc=0x010. start -> pc=0, flags cleared, running=1.
- rst_n pulsed low mid-run at pc=0x040 with LUT loaded -> asynchronously pc=0, IDLE, LUT all 0. A branch after the next start jumps to 0.

Source files
------------

// File: rtl/branch_pc_unit.sv
// -----------------------------------------------------------------------------
// branch_pc_unit
//   Program-counter and branch-resolution unit for the 8-bit core.
//   Captures the ALU compare flags (equal / lessThan) into a flag register and
//   resolves conditional branches against those registered flags. Branch
//   targets come from a small writable lookup table. The PC is sequenced by a
//   three-state FSM: IDLE -> RUN -> HALT (-> RUN again on start).
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   start        begin execution from PC 0 (accepted in IDLE or HALT)
//   stall        freeze PC, flags and FSM for this cycle (RUN only)
//   halt_req     current instruction is HALT
//   flag_we      current instruction is a compare; capture equal/lessThan
//   equal_in     ALU equal flag
//   lessThan_in  ALU lessThan flag
//   branch_en    current instruction is a branch
//   branch_cond  00 always, 01 if eq, 10 if lt, 11 if !eq
//   lut_idx      target-table entry used by the branch
//   lut_we       write target-table entry lut_waddr with lut_wdata
//   lut_waddr    target-table write address
//   lut_wdata    target-table write data
//   pc           current program counter
//   taken        one-cycle pulse: pc now holds a branch target
//   running      FSM is in RUN
//   done         FSM is in HALT
// -----------------------------------------------------------------------------
module branch_pc_unit #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              flag_we,
  input  logic              equal_in,
  input  logic              lessThan_in,
  input  logic              branch_en,
  input  logic [1:0]        branch_cond,
  input  logic [LUT_AW-1:0] lut_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              taken,
  output logic              running,
  output logic              done
);

  localparam int LUT_DEPTH = 2 ** LUT_AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'b00,
    COND_EQ     = 2'b01,
    COND_LT     = 2'b10,
    COND_NE     = 2'b11
  } cond_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              eq_q, eq_d;
  logic              lt_q, lt_d;
  logic              taken_q, taken_d;

  logic [PC_W-1:0]   lut_q [LUT_DEPTH];
  logic [PC_W-1:0]   lut_rdata;
  logic              cond_true;

  // ---------------------------------------------------------------------------
  // Target table: combinational read, registered write. Because the write is
  // non-blocking, a branch reading the entry being written this cycle sees the
  // old contents.
  // ---------------------------------------------------------------------------
  assign lut_rdata = lut_q[lut_idx];

  // NOTE: the table must read as all-zero after reset (including a mid-run
  // reset), so every entry is cleared asynchronously; this keeps it in flops
  // rather than a RAM macro, which is fine at this depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  // Branch condition is always judged on the registered flags, never on the
  // flags being captured this cycle.
  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(branch_cond))
      COND_ALWAYS: cond_true = 1'b1;
      COND_EQ:     cond_true = eq_q;
      COND_LT:     cond_true = lt_q;
      COND_NE:     cond_true = !eq_q;
      default:     cond_true = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-PC / next-flag logic.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    taken_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        // Stall, branch and flag inputs have no effect outside RUN.
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
        end
      end

      ST_RUN: begin
        if (!stall) begin
          if (halt_req) begin
            // Halt wins over branch and compare; pc keeps its pre-halt value.
            state_d = ST_HALT;
          end else begin
            if (branch_en && cond_true) begin
              pc_d    = lut_rdata;
              taken_d = 1'b1;
            end else begin
              pc_d = pc_q + PC_W'(1);   // wraps naturally at 2^PC_W
            end
            if (flag_we) begin
              eq_d = equal_in;
              lt_d = lessThan_in;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      taken_q <= taken_d;
    end
  end

  assign pc      = pc_q;
  assign taken   = taken_q;
  assign running = (state_q == ST_RUN);
  assign done    = (state_q == ST_HALT);

endmodule

// File: tb/tb_branch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_pc_unit
//   Directed bench for branch_pc_unit with hand-computed expected values.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_branch_pc_unit;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              stall;
  logic              halt_req;
  logic              flag_we;
  logic              equal_in;
  logic              lessThan_in;
  logic              branch_en;
  logic [1:0]        branch_cond;
  logic [LUT_AW-1:0] lut_idx;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc;
  logic              taken;
  logic              running;
  logic              done;

  int total = 0;
  int bad   = 0;

  branch_pc_unit #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stall       (stall),
    .halt_req    (halt_req),
    .flag_we     (flag_we),
    .equal_in    (equal_in),
    .lessThan_in (lessThan_in),
    .branch_en   (branch_en),
    .branch_cond (branch_cond),
    .lut_idx     (lut_idx),
    .lut_we      (lut_we),
    .lut_waddr   (lut_waddr),
    .lut_wdata   (lut_wdata),
    .pc          (pc),
    .taken       (taken),
    .running     (running),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; halt_req = 0; flag_we = 0;
    equal_in = 0; lessThan_in = 0; branch_en = 0; branch_cond = 2'b00;
    lut_idx = '0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
  endtask

  // Advance one clock; inputs set before the call are sampled at that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [1:0] cond, input logic [LUT_AW-1:0] idx);
    branch_en = 1; branch_cond = cond; lut_idx = idx;
  endtask

  task automatic lut_write(input logic [LUT_AW-1:0] a, input logic [PC_W-1:0] d);
    lut_we = 1; lut_waddr = a; lut_wdata = d;
  endtask

  task automatic expect_state(input string tag, input logic [PC_W-1:0] exp_pc,
                              input logic exp_taken, input logic exp_run, input logic exp_done);
    check({tag, ".pc"},      16'(pc),      16'(exp_pc));
    check({tag, ".taken"},   16'(taken),   16'(exp_taken));
    check({tag, ".running"}, 16'(running), 16'(exp_run));
    check({tag, ".done"},    16'(done),    16'(exp_done));
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #12;
    expect_state("reset", 10'h000, 0, 0, 0);
    rst_n = 1;
    step();
    expect_state("idle_no_start", 10'h000, 0, 0, 0);

    // Start, then free-run.
    start = 1; step(); start = 0;
    expect_state("start", 10'h000, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      expect_state($sformatf("seq%0d", i), PC_W'(i), 0, 1, 0);
    end

    // LUT[3]=0x120 together with compare eq=1, then branch if equal.
    lut_write(3, 10'h120); flag_we = 1; equal_in = 1;
    step(); idle_inputs();
    expect_state("cmp_eq", 10'h005, 0, 1, 0);
    branch(2'b01, 3); step(); idle_inputs();
    expect_state("beq_taken", 10'h120, 1, 1, 0);
    step();
    expect_state("beq_after", 10'h121, 0, 1, 0);

    // Clear flags, then same-cycle compare+branch must use old flags.
    flag_we = 1; step(); idle_inputs();
    expect_state("cmp_clear", 10'h122, 0, 1, 0);
    flag_we = 1; equal_in = 1; branch(2'b01, 3); step(); idle_inputs();
    expect_state("beq_sameCycle", 10'h123, 0, 1, 0);
    branch(2'b01, 3); step(); idle_inputs();
    expect_state("beq_nextCycle", 10'h120, 1, 1, 0);

    // lessThan branch.
    flag_we = 1; lessThan_in = 1; step(); idle_inputs();
    expect_state("cmp_lt", 10'h121, 0, 1, 0);
    branch(2'b10, 3); step(); idle_inputs();
    expect_state("blt_taken", 10'h120, 1, 1, 0);

    // Not-equal branch to 0x3FF, then wrap to 0.
    lut_write(5, 10'h3FF); step(); idle_inputs();
    expect_state("lut5_write", 10'h121, 0, 1, 0);
    branch(2'b11, 5); step(); idle_inputs();
    expect_state("bne_taken", 10'h3FF, 1, 1, 0);
    step();
    expect_state("wrap", 10'h000, 0, 1, 0);

    // eq=1, lt=0: bne and blt not taken.
    flag_we = 1; equal_in = 1; step(); idle_inputs();
    expect_state("cmp_eq2", 10'h001, 0, 1, 0);
    branch(2'b11, 5); step(); idle_inputs();
    expect_state("bne_not", 10'h002, 0, 1, 0);
    branch(2'b10, 5); step(); idle_inputs();
    expect_state("blt_not", 10'h003, 0, 1, 0);

    // Write and read the same entry in one cycle: old target used.
    lut_write(3, 10'h200); branch(2'b00, 3); step(); idle_inputs();
    expect_state("wr_rd_same", 10'h120, 1, 1, 0);
    branch(2'b00, 3); step(); idle_inputs();
    expect_state("rd_new", 10'h200, 1, 1, 0);

    // Jump to 0x005 and stall three cycles with everything else asserted.
    lut_write(6, 10'h005); step(); idle_inputs();
    branch(2'b00, 6); step(); idle_inputs();
    expect_state("to_5", 10'h005, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      stall = 1; halt_req = 1; flag_we = 1; lessThan_in = 1; branch(2'b00, 3);
      lut_write(7, 10'h010);
      step(); idle_inputs();
      expect_state($sformatf("stall%0d", i), 10'h005, 0, 1, 0);
    end
    // Flags must still be eq=1, lt=0; LUT[7] written during stall.
    branch(2'b10, 7); step(); idle_inputs();
    expect_state("post_stall_blt", 10'h006, 0, 1, 0);
    branch(2'b01, 7); step(); idle_inputs();
    expect_state("post_stall_beq", 10'h010, 1, 1, 0);

    // Halt beats branch and compare.
    halt_req = 1; branch(2'b00, 3); flag_we = 1; step(); idle_inputs();
    expect_state("halt", 10'h010, 0, 0, 1);
    branch(2'b00, 3); stall = 1; step(); idle_inputs();
    expect_state("halt_hold", 10'h010, 0, 0, 1);

    // Restart clears pc and flags (eq was 1 before).
    start = 1; step(); idle_inputs();
    expect_state("restart", 10'h000, 0, 1, 0);
    branch(2'b01, 7); step(); idle_inputs();
    expect_state("flags_cleared_beq", 10'h001, 0, 1, 0);
    branch(2'b11, 7); step(); idle_inputs();
    expect_state("flags_cleared_bne", 10'h010, 1, 1, 0);
    start = 1; step(); idle_inputs();
    expect_state("start_in_run", 10'h011, 0, 1, 0);

    // Mid-run asynchronous reset at pc=0x040.
    lut_write(8, 10'h040); step(); idle_inputs();
    branch(2'b00, 8); step(); idle_inputs();
    expect_state("to_40", 10'h040, 1, 1, 0);
    #2 rst_n = 0;
    #1;
    expect_state("async_reset", 10'h000, 0, 0, 0);
    #3 rst_n = 1;
    step();
    expect_state("post_reset_idle", 10'h000, 0, 0, 0);
    start = 1; step(); idle_inputs();
    expect_state("post_reset_start", 10'h000, 0, 1, 0);
    branch(2'b00, 8); step(); idle_inputs();
    expect_state("lut8_cleared", 10'h000, 1, 1, 0);
    branch(2'b00, 3); step(); idle_inputs();
    expect_state("lut3_cleared", 10'h000, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
